ps2_rx_frame: RTL and testbench

- Downstream consumer of the keyboard-line debouncer.
- Takes the debounced PS/2 clock and data lines, detects falling edges on the PS/2 clock, and assembles 11-bit device-to-host frames: start, 8 data bits LSB first, odd parity, stop.
- Delivers validated scan-code bytes as a one-cycle strobe to the keyboard decode/display logic, and flags parity, framing and timeout errors.

---
 rtl/ps2_rx_frame.sv | 146 ++++++++++++++
 tb/tb_ps2_rx_frame.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: start, 8 data bits LSB first, odd parity, stop.
// Optional `PS2_BREAK_TRACK_EN folds E0/F0 prefix bytes into key_ext/key_brk flags.
module ps2_rx_frame #(
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int TO_W           = 18
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       kclk,
  input  logic       kdata,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       key_brk,
  output logic       key_ext
);

  typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_t;

  state_t          state;
  logic            kclk_q;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;
  logic            par_bit;
  logic [TO_W-1:0] to_cnt;
  logic            fall;
  logic            timeout;

  assign fall    = kclk_q & ~kclk;
  assign timeout = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

`ifdef PS2_BREAK_TRACK_EN
  logic ext_pend;
  logic brk_pend;
`else
  assign key_brk = 1'b0;
  assign key_ext = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      kclk_q     <= 1'b1;
      state      <= IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      par_bit    <= 1'b0;
      to_cnt     <= '0;
      scan_code  <= '0;
      code_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
`ifdef PS2_BREAK_TRACK_EN
      key_brk    <= 1'b0;
      key_ext    <= 1'b0;
      ext_pend   <= 1'b0;
      brk_pend   <= 1'b0;
`endif
    end else begin
      kclk_q     <= kclk;
      code_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
`ifdef PS2_BREAK_TRACK_EN
      key_brk    <= 1'b0;
      key_ext    <= 1'b0;
`endif
      if (fall || state == IDLE)
        to_cnt <= '0;
      else
        to_cnt <= to_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (fall && !kdata) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (fall) begin
            shift   <= {kdata, shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7)
              state <= PAR;
          end
        end
        PAR: begin
          if (fall) begin
            par_bit <= kdata;
            state   <= STOP;
          end
        end
        STOP: begin
          if (fall) begin
            state <= IDLE;
            if (!kdata) begin
              frame_err <= 1'b1;
`ifdef PS2_BREAK_TRACK_EN
              ext_pend  <= 1'b0;
              brk_pend  <= 1'b0;
`endif
            end else if (!(^{shift, par_bit})) begin
              parity_err <= 1'b1;
`ifdef PS2_BREAK_TRACK_EN
              ext_pend   <= 1'b0;
              brk_pend   <= 1'b0;
`endif
            end else begin
`ifdef PS2_BREAK_TRACK_EN
              // Prefix bytes only arm the flags for the key code that follows them.
              if (shift == 8'hE0)
                ext_pend <= 1'b1;
              else if (shift == 8'hF0)
                brk_pend <= 1'b1;
              else begin
                scan_code  <= shift;
                code_valid <= 1'b1;
                key_ext    <= ext_pend;
                key_brk    <= brk_pend;
                ext_pend   <= 1'b0;
                brk_pend   <= 1'b0;
              end
`else
              scan_code  <= shift;
              code_valid <= 1'b1;
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase

      // A stalled kclk aborts the frame; a fall on the same cycle keeps it alive.
      if (state != IDLE && !fall && timeout) begin
        state     <= IDLE;
        frame_err <= 1'b1;
`ifdef PS2_BREAK_TRACK_EN
        ext_pend  <= 1'b0;
        brk_pend  <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Scoreboard bench for ps2_rx_frame; honours `PS2_BREAK_TRACK_EN in its expectation model.
module tb_ps2_rx_frame;

  localparam int T    = 200;
  localparam int HALF = 10;

  typedef enum int {EV_OK, EV_PAR, EV_FRM} ev_t;
  typedef struct {
    ev_t        kind;
    logic [7:0] code;
    logic       brk;
    logic       ext;
    int         due;
  } exp_t;

  logic       clk   = 1'b0;
  logic       rstn  = 1'b1;
  logic       kclk  = 1'b1;
  logic       kdata = 1'b1;
  logic [7:0] scan_code;
  logic       code_valid, parity_err, frame_err, key_brk, key_ext;

  int         cyc    = 0;
  int         checks = 0;
  int         errors = 0;
  exp_t       sb[$];
  logic [7:0] m_code;
  logic       m_ext, m_brk;

  ps2_rx_frame #(.TIMEOUT_CYCLES(T), .TO_W(8)) dut (
    .clk(clk), .rstn(rstn), .kclk(kclk), .kdata(kdata),
    .scan_code(scan_code), .code_valid(code_valid), .parity_err(parity_err),
    .frame_err(frame_err), .key_brk(key_brk), .key_ext(key_ext)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkv(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // Enter at a negedge with kclk high; kclk falls one cycle after kdata is set.
  task automatic clock_bit(input logic val, input int low_c, input int high_c, output int fall_cyc);
    kdata = val;
    @(negedge clk);
    kclk = 1'b0;
    fall_cyc = cyc;
    repeat (low_c) @(negedge clk);
    kclk = 1'b1;
    repeat (high_c) @(negedge clk);
  endtask

  task automatic expect_stop(input logic [7:0] d, input logic par_flip, input logic stop_v);
    exp_t e;
    e.due  = cyc + 2;
    e.brk  = 1'b0;
    e.ext  = 1'b0;
    e.code = m_code;
    e.kind = EV_OK;
    if (!stop_v) begin
      e.kind = EV_FRM; m_ext = 1'b0; m_brk = 1'b0; sb.push_back(e);
    end else if (par_flip) begin
      e.kind = EV_PAR; m_ext = 1'b0; m_brk = 1'b0; sb.push_back(e);
    end else begin
`ifdef PS2_BREAK_TRACK_EN
      if (d == 8'hE0) m_ext = 1'b1;
      else if (d == 8'hF0) m_brk = 1'b1;
      else begin
        e.code = d; e.brk = m_brk; e.ext = m_ext;
        m_code = d; m_brk = 1'b0; m_ext = 1'b0;
        sb.push_back(e);
      end
`else
      e.code = d; m_code = d; sb.push_back(e);
`endif
    end
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic par_flip, input logic stop_v);
    return {stop_v, (~^d) ^ par_flip, d, 1'b0};
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop_v,
                            input int low_c, input int high_c, input int stretch_bit);
    logic [10:0] bits;
    int fc, h;
    bits = frame_bits(d, par_flip, stop_v);
    for (int i = 0; i < 11; i++) begin
      h = (i == stretch_bit) ? (T - 1 - low_c) : high_c;
      if (i == 10) expect_stop(d, par_flip, stop_v);
      clock_bit(bits[i], low_c, h, fc);
    end
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n, output int last_fc);
    int fc;
    fc = 0;
    for (int i = 0; i < n; i++) clock_bit(bits[i], HALF, HALF, fc);
    last_fc = fc;
  endtask

  task automatic monitor();
    exp_t e;
    logic [2:0] pat;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (code_valid | parity_err | frame_err) begin
          if (sb.size() == 0)
            checkv("unexpected_strobe", {29'd0, code_valid, parity_err, frame_err}, 32'd0);
          else begin
            e = sb.pop_front();
            pat = (e.kind == EV_OK) ? 3'b100 : (e.kind == EV_PAR) ? 3'b010 : 3'b001;
            checkv("strobe_kind", {29'd0, code_valid, parity_err, frame_err}, {29'd0, pat});
            checkv("strobe_cycle", cyc, e.due);
            checkv("scan_code", {24'd0, scan_code}, {24'd0, e.code});
            checkv("key_flags", {30'd0, key_brk, key_ext}, {30'd0, e.brk, e.ext});
          end
        end else
          checkv("flags_idle", {30'd0, key_brk, key_ext}, 32'd0);
      end
    end
  endtask

  initial begin
    int   fc;
    exp_t e;
    m_code = 8'h00; m_ext = 1'b0; m_brk = 1'b0;
    fork monitor(); join_none
    #2 rstn = 1'b0;
    repeat (3) @(negedge clk);
    checkv("rst_scan_code", {24'd0, scan_code}, 32'd0);
    checkv("rst_code_valid", {31'd0, code_valid}, 32'd0);
    checkv("rst_parity_err", {31'd0, parity_err}, 32'd0);
    checkv("rst_frame_err", {31'd0, frame_err}, 32'd0);
    checkv("rst_key_flags", {30'd0, key_brk, key_ext}, 32'd0);
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    send_frame(8'h1C, 1'b0, 1'b1, HALF, HALF, -1);
    send_frame(8'h1C, 1'b1, 1'b1, HALF, HALF, -1);
    send_frame(8'h1C, 1'b0, 1'b0, HALF, HALF, -1);
    send_frame(8'h32, 1'b0, 1'b1, HALF, HALF, -1);

    // Stall after five data bits; the next start fall lands on the frame_err cycle.
    send_bits(frame_bits(8'h1C, 1'b0, 1'b1), 6, fc);
    e.kind = EV_FRM; e.code = m_code; e.brk = 1'b0; e.ext = 1'b0; e.due = fc + 1 + T;
    m_ext = 1'b0; m_brk = 1'b0;
    sb.push_back(e);
    while (cyc < fc + T) @(negedge clk);
    send_frame(8'h1C, 1'b0, 1'b1, HALF, HALF, -1);

    // A fall exactly on the timeout cycle keeps the frame alive.
    send_frame(8'h5A, 1'b0, 1'b1, HALF, HALF, 4);

    send_frame(8'h29, 1'b0, 1'b1, 1, 1, -1);
    send_frame(8'h66, 1'b0, 1'b1, 1, 1, -1);

    send_bits(frame_bits(8'h1C, 1'b0, 1'b1), 4, fc);
    rstn = 1'b0;
    #1;
    checkv("midrst_scan_code", {24'd0, scan_code}, 32'd0);
    checkv("midrst_strobes", {29'd0, code_valid, parity_err, frame_err}, 32'd0);
    checkv("midrst_key_flags", {30'd0, key_brk, key_ext}, 32'd0);
    m_code = 8'h00; m_ext = 1'b0; m_brk = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    send_frame(8'h1C, 1'b0, 1'b1, HALF, HALF, -1);

    send_frame(8'hE0, 1'b0, 1'b1, HALF, HALF, -1);
    send_frame(8'hF0, 1'b0, 1'b1, HALF, HALF, -1);
    send_frame(8'h75, 1'b0, 1'b1, HALF, HALF, -1);

    send_frame(8'hF0, 1'b0, 1'b1, HALF, HALF, -1);
    send_frame(8'h1C, 1'b1, 1'b1, HALF, HALF, -1);
    send_frame(8'h6B, 1'b0, 1'b1, HALF, HALF, -1);

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    checkv("scoreboard_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
